// File: rtl/fir_drv_pkg.sv
// Shared types and helpers for the FIR stream driver: controller state encoding
// and FIFO level widths.
package fir_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ISSUE       = 2'd1,
        ST_WAIT_RESULT = 2'd2,
        ST_ACK         = 2'd3
    } drv_state_e;

    // A level counter must be able to hold the value DEPTH itself.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fir_drv_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy output. The head
// word reads as zero while the FIFO is empty.
module fir_drv_fifo
    import fir_drv_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          iv_wdata,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          ov_rdata,
    output logic                      o_empty,
    output logic                      o_full,
    output logic [level_w(DEPTH)-1:0] ov_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= iv_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_empty  = (r_level == '0);
    assign o_full   = (r_level == LW'(DEPTH));
    assign ov_level = r_level;
    assign ov_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fir_stream_driver.sv
// Stream-side driver for handshake FIR filters: input FIFO -> one-at-a-time
// sample issue -> guarded result capture -> output FIFO. Optional WAIT_RESULT
// watchdog enabled by defining FIR_DRV_TIMEOUT_EN.
module fir_stream_driver
    import fir_drv_pkg::*;
#(
    parameter int DATA_WIDTH     = 24,
    parameter int IN_DEPTH       = 8,
    parameter int OUT_DEPTH      = 8,
    parameter int RESULT_GUARD   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_WIDTH-1:0]         iv_s_data,
    input  logic                          i_s_valid,
    output logic                          o_s_ready,
    output logic [DATA_WIDTH-1:0]         ov_fir_din,
    output logic                          o_fir_din_valid,
    input  logic                          i_fir_ready,
    input  logic [DATA_WIDTH-1:0]         iv_fir_dout,
    input  logic                          i_fir_dout_valid,
    output logic                          o_fir_dout_ready,
    output logic [DATA_WIDTH-1:0]         ov_m_data,
    output logic                          o_m_valid,
    input  logic                          i_m_ready,
    output logic [level_w(IN_DEPTH)-1:0]  ov_in_level,
    output logic [level_w(OUT_DEPTH)-1:0] ov_out_level,
    output logic                          o_timeout,
    output drv_state_e                    o_dbg_state
);

    // Handshakes: the stream sides transfer on any edge where valid && ready;
    // o_s_ready is !in_full only. Toward the filter, o_fir_din_valid is held
    // with stable data until an i_fir_ready pulse, and o_fir_dout_ready is a
    // single-cycle acknowledge of the result captured on the previous edge.
    localparam int GW = (RESULT_GUARD > 0) ? $clog2(RESULT_GUARD + 1) : 1;

    drv_state_e             r_state;
    drv_state_e             w_state_nxt;
    logic [DATA_WIDTH-1:0]  r_din;
    logic [GW-1:0]          r_guard;

    logic                   w_in_push;
    logic                   w_in_pop;
    logic [DATA_WIDTH-1:0]  w_in_head;
    logic                   w_in_empty;
    logic                   w_in_full;
    logic                   w_out_push;
    logic                   w_out_pop;
    logic                   w_out_empty;
    logic                   w_out_full;
    logic                   w_load_din;
    logic                   w_guard_clr;
    logic                   w_guard_done;
    logic                   w_wd_expired;

    assign w_in_push    = i_s_valid && !w_in_full;
    assign w_out_pop    = !w_out_empty && i_m_ready;
    assign w_guard_done = (r_guard == GW'(RESULT_GUARD));

    fir_drv_fifo #(.DEPTH(IN_DEPTH), .WIDTH(DATA_WIDTH)) u_in_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_push   (w_in_push),
        .iv_wdata (iv_s_data),
        .i_pop    (w_in_pop),
        .ov_rdata (w_in_head),
        .o_empty  (w_in_empty),
        .o_full   (w_in_full),
        .ov_level (ov_in_level)
    );

    fir_drv_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(DATA_WIDTH)) u_out_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_push   (w_out_push),
        .iv_wdata (iv_fir_dout),
        .i_pop    (w_out_pop),
        .ov_rdata (ov_m_data),
        .o_empty  (w_out_empty),
        .o_full   (w_out_full),
        .ov_level (ov_out_level)
    );

`ifdef FIR_DRV_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] r_wd;
    logic           r_timeout;

    assign w_wd_expired = (r_wd == WDW'(TIMEOUT_CYCLES - 1));

    // Watchdog restarts with each issued sample; the flag stays set until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_guard_clr) begin
                r_wd <= '0;
            end else if (r_state == ST_WAIT_RESULT) begin
                r_wd <= r_wd + 1'b1;
            end
            if (r_state == ST_WAIT_RESULT && !w_out_push && w_wd_expired) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_wd_expired = 1'b0;
    assign o_timeout    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_in_pop    = 1'b0;
        w_out_push  = 1'b0;
        w_load_din  = 1'b0;
        w_guard_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_in_empty && !w_out_full) begin
                    w_load_din  = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_fir_ready) begin
                    w_in_pop    = 1'b1;
                    w_guard_clr = 1'b1;
                    w_state_nxt = ST_WAIT_RESULT;
                end
            end
            ST_WAIT_RESULT: begin
                // A valid seen before the guard expires may be the previous result.
                if (w_guard_done && i_fir_dout_valid) begin
                    w_out_push  = 1'b1;
                    w_state_nxt = ST_ACK;
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_din   <= '0;
            r_guard <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_din) begin
                r_din <= w_in_head;
            end
            if (w_guard_clr) begin
                r_guard <= '0;
            end else if (r_state == ST_WAIT_RESULT && !w_guard_done) begin
                r_guard <= r_guard + 1'b1;
            end
        end
    end

    assign o_s_ready        = !w_in_full;
    assign ov_fir_din       = r_din;
    assign o_fir_din_valid  = (r_state == ST_ISSUE);
    assign o_fir_dout_ready = (r_state == ST_ACK);
    assign o_m_valid        = !w_out_empty;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver with a handshake filter model that
// returns sample ^ 0x000575. Define FIR_DRV_TIMEOUT_EN to cover the watchdog.
`timescale 1ns/1ps
module tb_fir_stream_driver;
    import fir_drv_pkg::*;

    localparam int W  = 24;
    localparam int G  = 4;
    localparam int TO = 16;
    localparam logic [W-1:0] MASK = 24'h000575;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [W-1:0] iv_s_data;
    logic         i_s_valid;
    logic         o_s_ready;
    logic [W-1:0] ov_fir_din;
    logic         o_fir_din_valid;
    logic         i_fir_ready;
    logic [W-1:0] iv_fir_dout;
    logic         i_fir_dout_valid;
    logic         o_fir_dout_ready;
    logic [W-1:0] ov_m_data;
    logic         o_m_valid;
    logic         i_m_ready;
    logic [3:0]   ov_in_level;
    logic [3:0]   ov_out_level;
    logic         o_timeout;
    drv_state_e   o_dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Filter model controls
    logic         m_respond;
    logic         m_sticky;
    int           m_lat;
    logic         m_busy;
    int           m_cnt;
    logic [W-1:0] m_pend;
    int           n_cyc;

    fir_stream_driver #(
        .DATA_WIDTH     (W),
        .IN_DEPTH       (8),
        .OUT_DEPTH      (8),
        .RESULT_GUARD   (G),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .iv_s_data        (iv_s_data),
        .i_s_valid        (i_s_valid),
        .o_s_ready        (o_s_ready),
        .ov_fir_din       (ov_fir_din),
        .o_fir_din_valid  (o_fir_din_valid),
        .i_fir_ready      (i_fir_ready),
        .iv_fir_dout      (iv_fir_dout),
        .i_fir_dout_valid (i_fir_dout_valid),
        .o_fir_dout_ready (o_fir_dout_ready),
        .ov_m_data        (ov_m_data),
        .o_m_valid        (o_m_valid),
        .i_m_ready        (i_m_ready),
        .ov_in_level      (ov_in_level),
        .ov_out_level     (ov_out_level),
        .o_timeout        (o_timeout),
        .o_dbg_state      (o_dbg_state)
    );

    // Clock and global time limit
    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0:       return o_fir_dout_ready;
            1:       return (o_dbg_state == ST_WAIT_RESULT);
            2:       return o_timeout;
            default: return (exp_q.size() == 0);
        endcase
    endfunction

    // Polls at negedges until the selected event, bounded by limit.
    task automatic wait_for(input string tag, input int sel, input int limit, output int n);
        n = 0;
        while (!cond(sel) && n < limit) begin
            @(negedge i_clk);
            n++;
        end
        chk(tag, W'(cond(sel)), W'(1));
    endtask

    task automatic send(input logic [W-1:0] d);
        int n = 0;
        while (!o_s_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk("send_ready", W'(o_s_ready), W'(1));
        i_s_valid = 1'b1;
        iv_s_data = d;
        @(negedge i_clk);
        i_s_valid = 1'b0;
    endtask

    // Filter model: one ready pulse per offered sample, result after m_lat cycles.
    initial begin
        i_fir_ready      = 1'b0;
        i_fir_dout_valid = 1'b0;
        iv_fir_dout      = '0;
        m_busy           = 1'b0;
        m_cnt            = 0;
        m_pend           = '0;
        forever begin
            @(negedge i_clk);
            #1;
            if (i_rst) begin
                i_fir_ready = 1'b0;
                m_busy      = 1'b0;
                if (!m_sticky) i_fir_dout_valid = 1'b0;
            end else begin
                i_fir_ready = 1'b0;
                if (o_fir_dout_ready && !m_sticky) i_fir_dout_valid = 1'b0;
                if (o_fir_din_valid) chk("single_outstanding", W'(m_busy), 24'd0);
                if (!m_busy && o_fir_din_valid && m_respond) begin
                    i_fir_ready = 1'b1;
                    m_busy      = 1'b1;
                    m_pend      = ov_fir_din ^ MASK;
                    m_cnt       = m_lat;
                    if (!m_sticky) i_fir_dout_valid = 1'b0;
                end else if (m_busy) begin
                    if (m_cnt == 0) begin
                        iv_fir_dout      = m_pend;
                        i_fir_dout_valid = 1'b1;
                        m_busy           = 1'b0;
                    end else begin
                        m_cnt--;
                    end
                end
            end
        end
    end

    // Scoreboard: every downstream transfer must match the expected queue head.
    initial begin
        forever begin
            @(negedge i_clk);
            #1;
            if (!i_rst && o_m_valid && i_m_ready) begin
                chk("out_expected", W'(exp_q.size() != 0), W'(1));
                if (exp_q.size() != 0) chk("m_data", ov_m_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        i_rst     = 1'b1;
        i_s_valid = 1'b0;
        iv_s_data = '0;
        i_m_ready = 1'b1;
        m_respond = 1'b1;
        m_sticky  = 1'b0;
        m_lat     = 3;
        repeat (3) @(negedge i_clk);

        // Reset state
        chk("rst_din_valid", W'(o_fir_din_valid), 24'd0);
        chk("rst_din", ov_fir_din, 24'd0);
        chk("rst_dout_ready", W'(o_fir_dout_ready), 24'd0);
        chk("rst_m_valid", W'(o_m_valid), 24'd0);
        chk("rst_m_data", ov_m_data, 24'd0);
        chk("rst_in_level", W'(ov_in_level), 24'd0);
        chk("rst_out_level", W'(ov_out_level), 24'd0);
        chk("rst_timeout", W'(o_timeout), 24'd0);
        chk("rst_state", W'(o_dbg_state), W'(ST_IDLE));
        i_rst = 1'b0;
        @(negedge i_clk);

        // Single sample, 20-cycle filter latency
        m_lat = 20;
        exp_q.push_back(24'h000456);
        send(24'h000123);
        chk("t1_in_level", W'(ov_in_level), 24'd1);
        chk("t1_valid_t1", W'(o_fir_din_valid), 24'd0);
        @(negedge i_clk);
        chk("t1_valid_t2", W'(o_fir_din_valid), 24'd1);
        chk("t1_din", ov_fir_din, 24'h000123);
        wait_for("t1_ack_seen", 0, 40, n_cyc);
        chk("t1_m_valid", W'(o_m_valid), 24'd1);
        chk("t1_m_data", ov_m_data, 24'h000456);
        chk("t1_out_level", W'(ov_out_level), 24'd1);
        @(negedge i_clk);
        chk("t1_ack_pulse", W'(o_fir_dout_ready), 24'd0);
        chk("t1_in_level_end", W'(ov_in_level), 24'd0);
        chk("t1_out_level_end", W'(ov_out_level), 24'd0);
        chk("t1_din_hold", ov_fir_din, 24'h000123);

        // Burst of 8 fills the input FIFO while the filter stalls
        m_respond = 1'b0;
        m_lat     = 2;
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] d;
            d = 24'h100000 + W'(i) * 24'h000111;
            exp_q.push_back(d ^ MASK);
            send(d);
        end
        chk("t2_in_level_full", W'(ov_in_level), 24'd8);
        chk("t2_s_ready_low", W'(o_s_ready), 24'd0);
        chk("t2_din_first", ov_fir_din, 24'h100000);
        m_respond = 1'b1;
        wait_for("t2_drained", 3, 500, n_cyc);
        @(negedge i_clk);
        chk("t2_in_level_end", W'(ov_in_level), 24'd0);
        chk("t2_out_level_end", W'(ov_out_level), 24'd0);

        // Downstream stalled: 8 results stored, 2 samples left waiting
        i_m_ready = 1'b0;
        m_lat     = 3;
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] d;
            d = 24'hA00000 + W'(i);
            exp_q.push_back(d ^ MASK);
            send(d);
        end
        repeat (150) @(negedge i_clk);
        chk("t3_out_level", W'(ov_out_level), 24'd8);
        chk("t3_in_level", W'(ov_in_level), 24'd2);
        chk("t3_no_issue", W'(o_fir_din_valid), 24'd0);
        chk("t3_state_idle", W'(o_dbg_state), W'(ST_IDLE));
        chk("t3_head", ov_m_data, 24'hA00575);
        i_m_ready = 1'b1;
        wait_for("t3_drained", 3, 400, n_cyc);
        @(negedge i_clk);
        chk("t3_levels_end", W'({ov_in_level, ov_out_level}), 24'd0);

        // Reset while waiting for a result
        m_lat = 1000;
        send(24'h0000FF);
        wait_for("t4_in_wait", 1, 20, n_cyc);
        repeat (3) @(negedge i_clk);
        chk("t4_timeout_low", W'(o_timeout), 24'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("t4_state", W'(o_dbg_state), W'(ST_IDLE));
        chk("t4_din", ov_fir_din, 24'd0);
        chk("t4_din_valid", W'(o_fir_din_valid), 24'd0);
        chk("t4_m_valid", W'(o_m_valid), 24'd0);
        chk("t4_levels", W'({ov_in_level, ov_out_level}), 24'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        m_lat = 3;
        exp_q.push_back(24'h00AEB8);
        send(24'h00ABCD);
        wait_for("t4_after_reset", 3, 100, n_cyc);

        // Sticky dout_valid from the previous result must be masked by the guard
        m_sticky = 1'b1;
        m_lat    = 2;
        exp_q.push_back(24'h000565);
        send(24'h000010);
        wait_for("t5_first", 3, 100, n_cyc);
        exp_q.push_back(24'h000555);
        send(24'h000020);
        wait_for("t5_in_wait", 1, 20, n_cyc);
        wait_for("t5_ack_seen", 0, 40, n_cyc);
        chk("t5_guard_cycles", W'(n_cyc), W'(G + 1));
        wait_for("t5_drained", 3, 20, n_cyc);
        m_sticky = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

`ifdef FIR_DRV_TIMEOUT_EN
        // Filter never answers: watchdog fires after TO cycles in WAIT_RESULT
        m_lat = 30;
        send(24'h000333);
        wait_for("t6_in_wait", 1, 20, n_cyc);
        wait_for("t6_timeout_seen", 2, 40, n_cyc);
        chk("t6_timeout_cycles", W'(n_cyc), W'(TO));
        chk("t6_state_idle", W'(o_dbg_state), W'(ST_IDLE));
        chk("t6_no_push", W'(ov_out_level), 24'd0);
        repeat (25) @(negedge i_clk);
        m_lat = 2;
        exp_q.push_back(24'h000202);
        send(24'h000777);
        wait_for("t6_next_sample", 3, 100, n_cyc);
        chk("t6_timeout_sticky", W'(o_timeout), 24'd1);
`else
        chk("t6_timeout_tied", W'(o_timeout), 24'd0);
`endif

        repeat (3) @(negedge i_clk);
        chk("final_queue_empty", W'(exp_q.size()), 24'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_stream_driver.md
# fir_stream_driver

Stream-side driver for the team's handshake-based FIR filters. Accepts samples from an upstream valid/ready stream into an input FIFO, and issues them one at a time to the filter's sample port (din/din_valid/ready). It collects each filtered result from the filter's output port (dout/dout_valid/ready) into an output FIFO for a downstream valid/ready consumer. It sits between the system sample stream and the filter, and is the initiator/consumer end of the filter's two handshakes.

## Interface
- DATA_WIDTH, 24, sample and result width
- IN_DEPTH, 8, input FIFO depth (power of 2, ≥2)
- OUT_DEPTH, 8, output FIFO depth (power of 2, ≥2)
- RESULT_GUARD, 4, cycles in WAIT_RESULT before filter dout_valid is honoured (masks a stale/sticky valid)
- TIMEOUT_CYCLES, 1024, WAIT_RESULT watchdog limit (used only with FIR_DRV_TIMEOUT_EN)

- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- iv_s_data  in  DATA_WIDTH  upstream sample
- i_s_valid  in  1  upstream sample valid
- o_s_ready  out  1  input FIFO not full
- ov_fir_din  out  DATA_WIDTH  sample to filter, registered
- o_fir_din_valid  out  1  sample offered to filter
- i_fir_ready  in  1  filter consumed sample (pulse)
- iv_fir_dout  in  DATA_WIDTH  filter result
- i_fir_dout_valid  in  1  filter result valid (level; may stay high)
- o_fir_dout_ready  out  1  result consumed, one-cycle pulse
- ov_m_data  out  DATA_WIDTH  output FIFO head
- o_m_valid  out  1  output FIFO not empty
- i_m_ready  in  1  downstream accepts
- ov_in_level  out  $clog2(IN_DEPTH)+1  input FIFO occupancy
- ov_out_level  out  $clog2(OUT_DEPTH)+1  output FIFO occupancy
- o_timeout  out  1  sticky watchdog flag (tied 0 without FIR_DRV_TIMEOUT_EN)

## Operation
- Upstream transfer when i_s_valid && o_s_ready; o_s_ready = !in_full (no dependence on same-cycle pop).
- Downstream transfer when o_m_valid && i_m_ready; ov_m_data is first-word-fall-through head.
- At most one sample outstanding in the filter at any time.
- FSM states IDLE, ISSUE, WAIT_RESULT, ACK:
  - IDLE: if in FIFO non-empty and out_level < OUT_DEPTH -> ISSUE; ov_fir_din <= in head.
  - ISSUE: o_fir_din_valid=1, ov_fir_din stable; on i_fir_ready -> pop in FIFO, clear guard counter, -> WAIT_RESULT.
  - WAIT_RESULT: guard counter increments up to RESULT_GUARD; when counter == RESULT_GUARD and i_fir_dout_valid -> push iv_fir_dout to out FIFO, -> ACK.
  - ACK: o_fir_dout_ready=1 for exactly this cycle; -> IDLE.
- i_fir_ready outside ISSUE, and i_fir_dout_valid outside WAIT_RESULT, are ignored.
- ov_fir_din holds the last issued sample until the next IDLE->ISSUE.
- Simultaneous push/pop on either FIFO: level unchanged, data order preserved; push when full / pop when empty cannot occur by construction.
- Data passes through unmodified; no arithmetic beyond pointer/level counters (pointers wrap modulo depth, levels saturate-free by construction).
- Reset mid-operation: FSM -> IDLE, FIFOs emptied, outstanding sample dropped; the filter shares i_rst.

## Timing
- All outputs reset to 0; FIFOs empty; state IDLE.
- Upstream accept at edge t -> in FIFO head visible t+1 -> state ISSUE and o_fir_din_valid high from t+2 (if out FIFO not full).
- i_fir_ready sampled high at edge r -> o_fir_din_valid low after r.
- Result captured at edge c -> o_m_valid and o_fir_dout_ready high in cycle after c; ov_out_level +1 after c.
- Earliest next issue: two cycles after capture (ACK, IDLE).

## Configuration
- FIR_DRV_TIMEOUT_EN defined: counter runs in WAIT_RESULT; reaching TIMEOUT_CYCLES without capture sets o_timeout (cleared only by reset), drops the sample, -> IDLE without push.
- Undefined: no counter, WAIT_RESULT waits indefinitely, o_timeout tied 0.

## Structure
- Package fir_drv_pkg: FSM state enum, level-width helper constants.
- Sub-module fir_drv_fifo: synchronous FWFT FIFO with level output, instantiated twice (input, output).

## Test plan
- Single sample 0x000123 with filter model returning 0x000456 after 20 cycles -> o_fir_din_valid high t+2, one o_fir_dout_ready pulse, ov_m_data=0x000456, levels return to 0.
- Burst of 8 samples with i_m_ready=1 -> o_s_ready drops when in level = 8; outputs emerge in order, never two outstanding issues.
- i_m_ready=0, 10 samples, OUT_DEPTH=8 -> exactly 8 results stored, no issue while out_level=8; releasing i_m_ready drains all 10 in order.
- Sticky i_fir_dout_valid held 1 from previous result -> no capture until RESULT_GUARD cycles in WAIT_RESULT.
- i_rst asserted while in WAIT_RESULT -> all outputs 0, levels 0 next cycle; following sample processes normally.
- FIR_DRV_TIMEOUT_EN with TIMEOUT_CYCLES=16, filter never responds -> o_timeout=1 after 16 cycles, FSM IDLE, next sample issued.
